// File: rtl/sync_fifo_rd_unpacker.sv
// Read-side consumer of a synchronous FIFO: prefetches words into a 2-entry buffer and streams
// each word out as RATIO narrower beats, LSB slice first, on a valid/ready interface.
`timescale 1ns/1ps

module sync_fifo_rd_unpacker #(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned RATIO      = 4,
    parameter bit          FWFT       = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        fifo_empty_i,
    input  logic [FIFO_WIDTH-1:0]       fifo_rd_data_i,
    output logic                        fifo_read_o,
    output logic [FIFO_WIDTH/RATIO-1:0] m_data_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic                        m_last_o,
    output logic [1:0]                  buf_count_o
);

    localparam int unsigned BeatW = FIFO_WIDTH / RATIO;
    localparam int unsigned CntW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((RATIO < 1) || ((FIFO_WIDTH % RATIO) != 0)) begin : g_bad_cfg
        $error("sync_fifo_rd_unpacker: FIFO_WIDTH must be a multiple of RATIO and RATIO >= 1");
    end

    logic [FIFO_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [CntW-1:0]       beat_q, beat_d;
    logic                  in_flight_q, in_flight_d;

    logic [FIFO_WIDTH-1:0] head;
    logic                  beat_last;
    logic                  transfer;
    logic                  pop_word;
    logic                  capture;
    logic [2:0]            credit;

    always_comb begin
        head        = mem_q[rd_ptr_q];
        m_valid_o   = (count_q != 2'd0);
        beat_last   = (beat_q == CntW'(RATIO - 1));
        m_last_o    = m_valid_o & beat_last;
        m_data_o    = head[beat_q * BeatW +: BeatW];
        buf_count_o = count_q;
        transfer    = m_valid_o & m_ready_i;
        pop_word    = transfer & m_last_o;
        // Words held plus words on their way in, minus the one leaving this edge.
        credit      = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop_word};
        fifo_read_o = !rst_i & !fifo_empty_i & (credit < 3'd2);
        // Standard mode sees the popped word one cycle after the request.
        capture     = FWFT ? fifo_read_o : in_flight_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_d      = beat_q;
        in_flight_d = FWFT ? 1'b0 : fifo_read_o;
        if (capture) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_word) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (transfer) begin
            beat_d = beat_last ? '0 : beat_q + CntW'(1);
        end
        count_d = count_q + {1'b0, capture} - {1'b0, pop_word};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            beat_q      <= '0;
            in_flight_q <= 1'b0;
        end else begin
            if (capture) begin
                mem_q[wr_ptr_q] <= fifo_rd_data_i;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            in_flight_q <= in_flight_d;
        end
    end

endmodule
